// File: rtl/skey_fetch_ctrl_pkg.sv
// skey_fetch_ctrl_pkg: shared state encoding, key size derivation and null key value
package skey_fetch_ctrl_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic [15:0] NULL_KEY = 16'h0000;
    function automatic int key_words(input int mem_size);
        return mem_size / 2;
    endfunction
endpackage

// File: rtl/skey_fetch_ctrl.sv
// skey_fetch_ctrl: authorised, backpressured key ROM streamer
module skey_fetch_ctrl
    import skey_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_MSB = 4,
    parameter int MEM_SIZE = 20
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              auth,
    output logic [ADDR_MSB:0] rom_addr,
    output logic              rom_cen,
    input  logic [15:0]       rom_dout,
    output logic [15:0]       key_word,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int KW = key_words(MEM_SIZE);
    localparam logic [ADDR_MSB:0] LAST = (ADDR_MSB+1)'(KW-1);
    localparam logic [ADDR_MSB:0] ONE  = (ADDR_MSB+1)'(1);
    state_t            r_state, w_state_nxt;
    logic [ADDR_MSB:0] r_idx, w_idx_nxt;
    logic              r_done, r_err, w_done_nxt, w_err_nxt;
    logic              w_run, w_start_ok, w_xfer, w_at_last, w_adv;
    assign w_run      = r_state == ST_RUN;
    assign w_start_ok = !w_run & start & auth;
    assign key_valid  = w_run & auth;
    assign w_xfer     = key_valid & key_ready;
    assign w_at_last  = r_idx == LAST;
    assign w_adv      = w_xfer & !w_at_last;
    // Reads are issued only on start or on an accepted word, so a stall keeps rom_dout stable
    assign rom_cen    = !(w_start_ok | w_adv);
    assign rom_addr   = w_adv ? r_idx + ONE : '0;
    assign key_word   = key_valid ? rom_dout : NULL_KEY;
    assign key_last   = key_valid & w_at_last;
    assign busy       = w_run;
    assign done       = r_done;
    assign err        = r_err;
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (!w_run) begin
            w_state_nxt = w_start_ok ? ST_RUN : ST_IDLE;
            w_idx_nxt   = '0;
            w_err_nxt   = start & !auth;
        end else if (!auth) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_err_nxt   = 1'b1;
        end else if (w_xfer) begin
            w_state_nxt = w_at_last ? ST_IDLE : ST_RUN;
            w_idx_nxt   = w_at_last ? '0 : r_idx + ONE;
            w_done_nxt  = w_at_last;
        end
    end
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_skey_fetch_ctrl.sv
// tb_skey_fetch_ctrl: directed test plan plus random traffic against a word-count reference model
module tb_skey_fetch_ctrl;
    localparam int KW = 10;
    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1, start = 1'b0, auth = 1'b0, key_ready = 1'b0;
    logic [4:0]  rom_addr;
    logic        rom_cen;
    logic [15:0] rom_dout = 16'h0000;
    logic [15:0] key_word;
    logic        key_valid, key_last, busy, done, err;
    logic [15:0] rom [0:31];
    int          n_vec = 0, n_err = 0, n_cen = 0, n_done = 0;
    bit          m_run = 0, m_done = 0, m_err = 0;
    int          m_n = 0;
    skey_fetch_ctrl #(.ADDR_MSB(4), .MEM_SIZE(20)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .auth(auth),
        .rom_addr(rom_addr), .rom_cen(rom_cen), .rom_dout(rom_dout),
        .key_word(key_word), .key_valid(key_valid), .key_ready(key_ready),
        .key_last(key_last), .busy(busy), .done(done), .err(err)
    );
    always #5 mclk = ~mclk;
    always @(posedge mclk) if (!rom_cen) rom_dout <= rom[rom_addr];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // One clock: drive, check outputs against the model mid-cycle, then advance the model at the edge
    task automatic cyc(input logic s, input logic a, input logic r, input logic x);
        bit v, rd;
        @(negedge mclk);
        start = s; auth = a; key_ready = r; puc_rst = x;
        #1;
        v  = m_run && a;
        rd = (!m_run && s && a) || (v && r && m_n < KW-1);
        chk("busy", busy, m_run);
        chk("key_valid", key_valid, v);
        chk("key_word", key_word, v ? rom[m_n] : 16'h0000);
        chk("key_last", key_last, v && m_n == KW-1);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("rom_cen", rom_cen, !rd);
        if (rd) chk("rom_addr", rom_addr, m_run ? m_n + 1 : 0);
        chk("addr_range", rom_addr < KW, 1);
        if (!rom_cen) n_cen++;
        if (done) n_done++;
        @(posedge mclk);
        if (x) begin
            m_run = 0; m_n = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (!m_run) begin
                if (s && a) begin m_run = 1; m_n = 0; end
                else if (s) m_err = 1;
            end else if (!a) begin
                m_run = 0; m_n = 0; m_err = 1;
            end else if (r) begin
                if (m_n == KW-1) begin m_run = 0; m_n = 0; m_done = 1; end
                else m_n++;
            end
        end
    endtask
    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0123; rom[1] = 16'h4567; rom[2] = 16'h89ab; rom[3] = 16'hcdef;
        repeat (2) @(posedge mclk);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0);
        // full stream
        n_cen = 0;
        cyc(1, 1, 1, 0);
        repeat (KW) cyc(0, 1, 1, 0);
        chk("stream_cen_cnt", n_cen, KW);
        cyc(0, 1, 1, 0);
        // backpressure on word 2
        n_cen = 0;
        cyc(1, 1, 1, 0);
        repeat (2) cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (KW-2) cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("bp_cen_cnt", n_cen, KW);
        // denied start
        n_cen = 0;
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("deny_cen_cnt", n_cen, 0);
        // abort after 4 words, then restart
        cyc(1, 1, 1, 0);
        repeat (4) cyc(0, 1, 1, 0);
        n_cen = 0;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("abort_cen_cnt", n_cen, 0);
        cyc(1, 1, 1, 0);
        repeat (KW) cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        // reset during word 5
        n_done = 0;
        cyc(1, 1, 1, 0);
        repeat (5) cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("rst_no_done", n_done, 0);
        // start during RUN ignored
        n_done = 0;
        cyc(1, 1, 1, 0);
        repeat (3) cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        repeat (KW-4) cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 1, 0);
        chk("ign_done_cnt", n_done, 1);
        // random traffic with fresh ROM contents
        for (int i = 0; i < KW; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/skey_fetch_ctrl.md
Name: skey_fetch_ctrl

Overview:
- Sequencer and access gate for the secret-key ROM (keyrom) in the attestation path.
- On a start request it streams every 16-bit key word, in address order, to a consumer (the HMAC key-load port) over a valid/ready handshake.
- It accounts for the ROM's one-cycle registered-address latency and honours consumer backpressure.
- It only reads the ROM while the attestation-authorisation signal is high. Loss of authorisation aborts the transfer and stops output of key data.

Parameters:
- ADDR_MSB, 4: MSB of the ROM word address, index width ADDR_MSB+1.
- MEM_SIZE, 20: key ROM size in bytes; KEY_WORDS = MEM_SIZE/2 = 10 words.

Ports:
- mclk, input, 1: system clock.
- puc_rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to stream the key.
- auth, input, 1: high while the trusted attestation code executes.
- rom_addr, output, ADDR_MSB+1: word address to keyrom.
- rom_cen, output, 1: keyrom chip enable, active low.
- rom_dout, input, 16: keyrom data; valid the cycle after an enabled read and held until the next enabled read.
- key_word, output, 16: streamed key word.
- key_valid, output, 1: key_word is valid.
- key_ready, input, 1: consumer accepts the word.
- key_last, output, 1: the current word is index KEY_WORDS-1.
- busy, output, 1: a transfer is in progress.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: one-cycle pulse on a denied start or an abort.

Behaviour:
- Clock and reset: one clock, mclk. puc_rst is synchronous and active-high.
- Reset values: state IDLE, idx=0, busy=0, key_valid=0, key_last=0, done=0, err=0, rom_cen=1, rom_addr=0, key_word=0. Reset mid-transfer discards it with no done and no err.
- States: IDLE, RUN.
- IDLE:
  - start&auth: drive rom_cen=0 and rom_addr=0 combinationally in the same cycle, set idx=0, go to RUN.
  - start&!auth: err=1 next cycle, no ROM access, stay in IDLE.
- RUN:
  - busy=1.
  - key_valid = auth, combinationally.
  - key_word = rom_dout when key_valid, else 16'h0000.
  - key_last = key_valid & (idx==KEY_WORDS-1).
  - First word latency: key_valid rises 1 cycle after the accepted start.
- Handshake:
  - Transfer occurs on key_valid&key_ready.
  - Transfer with idx<KEY_WORDS-1: same cycle rom_cen=0 and rom_addr=idx+1; idx increments. The next word is presented the following cycle, so throughput is 1 word/cycle.
  - Transfer with idx==KEY_WORDS-1: go to IDLE; done=1 in the next cycle; rom_cen stays 1.
  - !key_ready: rom_cen=1. The word is held because rom_dout is stable. key_valid must not drop except on abort.
- ROM address range: rom_addr never exceeds KEY_WORDS-1. rom_cen=1 in every cycle not listed above.
- Abort: auth low in any RUN cycle.
  - No transfer, no ROM read, key_word=0 that cycle.
  - Next cycle: IDLE, err=1, idx=0.
- start while in RUN is ignored.
- start coincident with the done or err cycle is accepted normally, because state is already IDLE.
- done and err are never high together.

Decomposition:
- Shared include/package holds:
  - state encodings ST_IDLE and ST_RUN;
  - the KEY_WORDS derivation;
  - the null key value, 16'h0000.
- No sub-module. The word-index counter lives inline.
- keyrom is instantiated only in the testbench and the top level.

Test Plan:
- Full stream: ROM = 0x0123,0x4567,0x89ab,0xcdef, then 0x0000 x6; auth=1, start pulse, key_ready=1.
  - Required: 10 consecutive transfers with the data in order.
  - key_last only on the 10th.
  - done one cycle after, busy low.
  - Exactly 10 rom_cen-low cycles.
- Backpressure: key_ready low for 3 cycles on word 2.
  - Required: key_word holds 0x89ab and key_valid stays 1.
  - rom_cen=1 during the stall; a single read of address 3 on acceptance.
- Denied start: auth=0, start pulse.
  - Required: err pulse next cycle, rom_cen never low, key_valid=0.
- Abort: auth drops after 4 words have transferred.
  - Required: that cycle key_valid=0 and key_word=0.
  - err next cycle; no rom_cen-low after the drop; a fresh start then restarts at address 0.
- Reset mid-transfer: puc_rst high during word 5.
  - Required: all outputs at reset values the next cycle, no done or err.
- Ignored start: start pulse during RUN.
  - Required: sequence unaffected, and exactly one done.
